// File: rtl/uart_tx_frame_scheduler.sv
// Repeating 3-byte status frame (game state, target, operation) onto a UART TX
// valid/ready interface, with zero-byte substitution and a programmable inter-byte gap.
module uart_tx_frame_scheduler #(
  parameter int         GAP_CYCLES = 0,
  parameter logic [7:0] FILL_BYTE  = 8'h01
) (
  input  logic       uart_clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] data_game_state,
  input  logic [7:0] data_target,
  input  logic [7:0] data_operate_verified,
  input  logic       op_valid,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic [7:0] frame_cnt,
  output logic [7:0] led
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [1:0] SLOT_GS = 2'd0;
  localparam logic [1:0] SLOT_TG = 2'd1;
  localparam logic [1:0] SLOT_OP = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_GAP     = 2'd2
  } state_t;

  state_t           state;
  logic [1:0]       slot;
  logic             op_pending;
  logic             op_overflow;
  logic [7:0]       op_buf;
  logic [GAP_W-1:0] gap_cnt;

  logic [1:0] cur_slot;
  logic [1:0] adv_slot;
  logic [1:0] load_slot;
  logic       accept;
  logic       op_clear;
  logic [7:0] load_byte;

  function automatic logic [7:0] no_zero(input logic [7:0] b);
    return (b == 8'h00) ? FILL_BYTE : b;
  endfunction

  function automatic logic [1:0] next_slot(input logic [1:0] s);
    case (s)
      SLOT_GS: return SLOT_TG;
      SLOT_TG: return SLOT_OP;
      default: return SLOT_GS;
    endcase
  endfunction

  // A strobe arriving on the edge that loads the OPERATE slot is forwarded so it is not lost.
  function automatic logic [7:0] slot_byte(input logic [1:0] s,
                                           input logic [7:0] gs,
                                           input logic [7:0] tg,
                                           input logic       strobe,
                                           input logic [7:0] op_in,
                                           input logic       pend,
                                           input logic [7:0] buf_q);
    case (s)
      SLOT_GS: return gs;
      SLOT_TG: return tg;
      default: begin
        if (strobe)    return op_in;
        else if (pend) return buf_q;
        else           return FILL_BYTE;
      end
    endcase
  endfunction

  always_comb begin
    cur_slot  = (slot == 2'b11) ? SLOT_GS : slot;
    adv_slot  = next_slot(cur_slot);
    accept    = (state == ST_PRESENT) && tx_ready;
    op_clear  = accept && (cur_slot == SLOT_OP);
    load_slot = accept ? adv_slot : cur_slot;
    load_byte = no_zero(slot_byte(load_slot, data_game_state, data_target, op_valid,
                                  data_operate_verified, op_pending, op_buf));
  end

  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      slot      <= SLOT_GS;
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      frame_cnt <= 8'h00;
      gap_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          slot <= cur_slot;
          if (enable) begin
            tx_data  <= load_byte;
            tx_valid <= 1'b1;
            state    <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (tx_ready) begin
            slot <= adv_slot;
            if (cur_slot == SLOT_OP) frame_cnt <= frame_cnt + 8'd1;
            if (GAP_CYCLES > 0) begin
              tx_valid <= 1'b0;
              gap_cnt  <= GAP_W'(GAP_CYCLES - 1);
              state    <= ST_GAP;
            end else if (enable) begin
              tx_data <= load_byte;
            end else begin
              tx_valid <= 1'b0;
              state    <= ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            slot <= cur_slot;
            if (enable) begin
              tx_data  <= load_byte;
              tx_valid <= 1'b1;
              state    <= ST_PRESENT;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: begin
          tx_valid <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  // A new strobe wins over the clear so an op landing on the OPERATE accept goes next frame.
  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      op_pending  <= 1'b0;
      op_overflow <= 1'b0;
      op_buf      <= 8'h00;
    end else begin
      if (op_valid) begin
        op_buf     <= data_operate_verified;
        op_pending <= 1'b1;
        if (op_pending && !op_clear) op_overflow <= 1'b1;
      end else if (op_clear) begin
        op_pending <= 1'b0;
      end
    end
  end

  assign led = {op_pending, op_overflow, slot, frame_cnt[3:0]};

endmodule
